vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. Successor to the fixed 640x480 controller.
//  Adds configurable sync polarity, wider counters, full x/y coordinates and line/frame strobes.
//  Adds a frame counter, a run enable, and a PIPE_DLY output delay line that aligns the
//  timing outputs with a downstream pixel pipeline. Sits between the pixel clock and the
//  frame-buffer / pattern logic feeding the DAC pins.
// PARAMETERS
//  HVID     640  active pixels per line
//  HFP      16   horizontal front porch, pixel clocks
//  HS       96   hsync pulse width, pixel clocks
//  HBP      48   horizontal back porch, pixel clocks
//  VVID     480  active lines per frame
//  VFP      10   vertical front porch, lines
//  VS       2    vsync pulse width, lines
//  VBP      33   vertical back porch, lines
//  HS_POL   0    hsync active level (0 = active-low, as VGA 640x480)
//  VS_POL   0    vsync active level
//  CW       11   width of x/y counters; must hold HVID+HFP+HS+HBP-1 and VVID+VFP+VS+VBP-1
//  FCW      8    frame counter width
//  PIPE_DLY 0    extra register stages on every output (0..15)
// PORTS
//  clk_25      in   1    pixel clock
//  rst_n       in   1    asynchronous active-low reset
//  en          in   1    run enable; 0 holds raster at origin
//  hsync       out  1    horizontal sync, polarity HS_POL
//  vsync       out  1    vertical sync, polarity VS_POL
//  video_on    out  1    1 inside the active HVID x VVID window
//  pixel_x     out  CW   current column, raw count 0..HTOT-1
//  pixel_y     out  CW   current line, raw count 0..VTOT-1
//  line_start  out  1    1-cycle pulse at x==0
//  frame_start out  1    1-cycle pulse at x==0 && y==0
//  frame_cnt   out  FCW  completed-frame count, wraps modulo 2^FCW
// BEHAVIOUR
//  - HTOT=HVID+HFP+HS+HBP, VTOT=VVID+VFP+VS+VBP. Registers: h_cnt, v_cnt, decode stage,
//    then PIPE_DLY delay stages.
//  - Reset (rst_n=0, async): h_cnt=v_cnt=0, frame_cnt=0, every pipeline stage cleared.
//    Cleared values: hsync=~HS_POL, vsync=~VS_POL, video_on=0, pixel_x=pixel_y=0,
//    line_start=frame_start=0.
//  - Counting (en=1): h_cnt increments each clock, wraps HTOT-1 -> 0. v_cnt increments
//    when h_cnt wraps, wraps VTOT-1 -> 0. frame_cnt increments (mod 2^FCW) on the cycle
//    both counters wrap together.
//  - en=0: h_cnt and v_cnt are forced to 0 synchronously. The decode stage loads blank
//    values: syncs inactive, video_on=0, pulses 0, x=y=0. frame_cnt holds.
//    Delay stages keep shifting. The first en=1 cycle counts from (0,0) and frame_start
//    fires for it; frame_cnt does not increment on restart.
//  - Decode of the counter value (h,v) in a given cycle:
//      video_on    = h<HVID && v<VVID
//      hsync       = HS_POL when HVID+HFP <= h < HVID+HFP+HS
//      vsync       = VS_POL when VVID+VFP <= v < VVID+VFP+VS, for the whole line
//      line_start  = h==0
//      frame_start = h==0 && v==0
//  - Latency: all outputs change together and are fully registered (no glitches). Each
//    describes the counter value 1+PIPE_DLY cycles earlier. frame_cnt is delayed identically.
//  - After reset release with en=1: outputs hold reset values for 1+PIPE_DLY cycles.
//    Then frame_start=1, line_start=1, video_on=1, pixel_x=pixel_y=0.
//  - Reset mid-frame: immediate return to reset values; restart as above.
//  - pixel_x/pixel_y are not masked in blanking. Consumers qualify them with video_on.
// TESTING  (small timing: HVID=8 HFP=2 HS=3 HBP=1 VVID=4 VFP=1 VS=2 VBP=1, HTOT=14, VTOT=8)
//  1 Reset, release with en=1, PIPE_DLY=0 -> cycle 1: frame_start=1, video_on=1, x=0,y=0.
//    x=7 at cycle 8; video_on=0 at x=8.
//  2 Run one line -> hsync=HS_POL for exactly x=10..12 (3 cycles). line_start every 14 cycles.
//  3 Run 2 frames -> vsync active for y=5..6 (28 cycles). frame_start every 112 cycles.
//    frame_cnt goes 0->1->2.
//  4 FCW=2, run 5 frames -> frame_cnt 0,1,2,3,0,1. Wrap happens with no stall.
//  5 en=0 at x=5,y=2 for 4 cycles, then en=1 -> blank outputs next cycle. Restart at (0,0)
//    with frame_start and frame_cnt unchanged.
//  6 PIPE_DLY=3, and rst_n pulsed mid-frame -> outputs cleared asynchronously.
//    After release the first frame_start appears at cycle 4. Sequence matches case 1 shifted by 3.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, a registered decode stage and
// an optional output delay line that keeps every timing output aligned.
module vga_timing_gen #(
    parameter int   HVID     = 640,
    parameter int   HFP      = 16,
    parameter int   HS       = 96,
    parameter int   HBP      = 48,
    parameter int   VVID     = 480,
    parameter int   VFP      = 10,
    parameter int   VS       = 2,
    parameter int   VBP      = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 11,
    parameter int   FCW      = 8,
    parameter int   PIPE_DLY = 0
) (
    input  logic           clk_25,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           video_on,
    output logic [CW-1:0]  pixel_x,
    output logic [CW-1:0]  pixel_y,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int HTOT = HVID + HFP + HS + HBP;
    localparam int VTOT = VVID + VFP + VS + VBP;
    localparam int OW   = 5 + 2 * CW + FCW;

    localparam logic [CW-1:0] H_LAST = CW'(HTOT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VTOT - 1);
    localparam logic [CW-1:0] H_VID  = CW'(HVID);
    localparam logic [CW-1:0] V_VID  = CW'(VVID);
    localparam logic [CW-1:0] HS_BEG = CW'(HVID + HFP);
    localparam logic [CW-1:0] HS_END = CW'(HVID + HFP + HS);
    localparam logic [CW-1:0] VS_BEG = CW'(VVID + VFP);
    localparam logic [CW-1:0] VS_END = CW'(VVID + VFP + VS);

    // Output bundle order: hsync, vsync, video_on, line_start, frame_start, x, y, frame_cnt
    localparam logic [OW-1:0] RST_VEC = {~HS_POL, ~VS_POL, 3'b000, {(2 * CW + FCW){1'b0}}};

    logic [CW-1:0]  h_cnt_r;
    logic [CW-1:0]  v_cnt_r;
    logic [CW-1:0]  h_nxt_s;
    logic [CW-1:0]  v_nxt_s;
    logic [FCW-1:0] frame_cnt_r;
    logic [FCW-1:0] frame_nxt_s;
    logic           hs_act_s;
    logic           vs_act_s;
    logic           vid_s;
    logic           ls_s;
    logic           fs_s;
    logic [OW-1:0]  dec_s;
    logic [OW-1:0]  pipe_r [PIPE_DLY+1];

    // Next raster position and frame count; disabled raster parks at the origin
    always_comb begin
        h_nxt_s     = h_cnt_r;
        v_nxt_s     = v_cnt_r;
        frame_nxt_s = frame_cnt_r;
        if (!en) begin
            h_nxt_s = {CW{1'b0}};
            v_nxt_s = {CW{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_nxt_s = {CW{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_nxt_s     = {CW{1'b0}};
                frame_nxt_s = frame_cnt_r + FCW'(1);
            end else begin
                v_nxt_s = v_cnt_r + CW'(1);
            end
        end else begin
            h_nxt_s = h_cnt_r + CW'(1);
        end
    end

    // Raster counters and completed-frame counter
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r     <= {CW{1'b0}};
            v_cnt_r     <= {CW{1'b0}};
            frame_cnt_r <= {FCW{1'b0}};
        end else begin
            h_cnt_r     <= h_nxt_s;
            v_cnt_r     <= v_nxt_s;
            frame_cnt_r <= frame_nxt_s;
        end
    end

    // Decode of the current counter value into the output bundle
    always_comb begin
        hs_act_s = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
        vs_act_s = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
        vid_s    = (h_cnt_r < H_VID) && (v_cnt_r < V_VID);
        ls_s     = (h_cnt_r == {CW{1'b0}});
        fs_s     = ls_s && (v_cnt_r == {CW{1'b0}});
        dec_s    = {~HS_POL, ~VS_POL, 3'b000, {(2 * CW){1'b0}}, frame_cnt_r};
        if (en) begin
            dec_s = {(hs_act_s ? HS_POL : ~HS_POL), (vs_act_s ? VS_POL : ~VS_POL),
                     vid_s, ls_s, fs_s, h_cnt_r, v_cnt_r, frame_cnt_r};
        end else begin
            dec_s = {~HS_POL, ~VS_POL, 3'b000, {(2 * CW){1'b0}}, frame_cnt_r};
        end
    end

    // Decode stage followed by PIPE_DLY plain delay stages
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                pipe_r[i] <= RST_VEC;
            end
        end else begin
            pipe_r[0] <= dec_s;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign {hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y, frame_cnt} =
        pipe_r[PIPE_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 14x8 raster: three instances
// (baseline, 2-bit frame counter, 3-stage delay) checked against a bench model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ls;
        logic        fs;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  fc;
    } out_t;

    typedef struct {
        int   cyc;
        logic hs;
        logic vid;
        logic ls;
        logic fs;
        int   x;
        int   y;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;

    logic        d0_hs, d0_vs, d0_vid, d0_ls, d0_fs;
    logic [10:0] d0_x, d0_y;
    logic [7:0]  d0_fc;
    logic        d2_hs, d2_vs, d2_vid, d2_ls, d2_fs;
    logic [10:0] d2_x, d2_y;
    logic [1:0]  d2_fc;
    logic        d3_hs, d3_vs, d3_vid, d3_ls, d3_fs;
    logic [10:0] d3_x, d3_y;
    logic [7:0]  d3_fc;

    vga_timing_gen #(.HVID(8), .HFP(2), .HS(3), .HBP(1), .VVID(4), .VFP(1), .VS(2), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .FCW(8), .PIPE_DLY(0)) d0 (
        .clk_25(clk), .rst_n(rst_n), .en(en), .hsync(d0_hs), .vsync(d0_vs),
        .video_on(d0_vid), .pixel_x(d0_x), .pixel_y(d0_y), .line_start(d0_ls),
        .frame_start(d0_fs), .frame_cnt(d0_fc));

    vga_timing_gen #(.HVID(8), .HFP(2), .HS(3), .HBP(1), .VVID(4), .VFP(1), .VS(2), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .FCW(2), .PIPE_DLY(0)) d2 (
        .clk_25(clk), .rst_n(rst_n), .en(en), .hsync(d2_hs), .vsync(d2_vs),
        .video_on(d2_vid), .pixel_x(d2_x), .pixel_y(d2_y), .line_start(d2_ls),
        .frame_start(d2_fs), .frame_cnt(d2_fc));

    vga_timing_gen #(.HVID(8), .HFP(2), .HS(3), .HBP(1), .VVID(4), .VFP(1), .VS(2), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .FCW(8), .PIPE_DLY(3)) d3 (
        .clk_25(clk), .rst_n(rst_n), .en(en), .hsync(d3_hs), .vsync(d3_vs),
        .video_on(d3_vid), .pixel_x(d3_x), .pixel_y(d3_y), .line_start(d3_ls),
        .frame_start(d3_fs), .frame_cnt(d3_fc));

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;
    int   mh, mv, mfc;
    int   hs_low = 0, vs_low = 0, fs_cnt = 0;
    out_t q0[$];
    out_t q3[$];
    vec_t tbl[7];

    localparam out_t RST = '{hs: 1'b1, vs: 1'b1, vid: 1'b0, ls: 1'b0, fs: 1'b0,
                             x: 11'd0, y: 11'd0, fc: 8'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic out_t model_dec(input int h, input int v, input logic e, input int fc);
        out_t o;
        o.hs  = !(h >= 10 && h <= 12);
        o.vs  = !(v >= 5 && v <= 6);
        o.vid = (h < 8) && (v < 4);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.x   = 11'(h);
        o.y   = 11'(v);
        o.fc  = 8'(fc);
        if (!e) begin
            o = RST;
            o.fc = 8'(fc);
        end
        return o;
    endfunction

    function automatic out_t d0_out();
        return {d0_hs, d0_vs, d0_vid, d0_ls, d0_fs, d0_x, d0_y, d0_fc};
    endfunction
    function automatic out_t d2_out();
        return {d2_hs, d2_vs, d2_vid, d2_ls, d2_fs, d2_x, d2_y, 6'b000000, d2_fc};
    endfunction
    function automatic out_t d3_out();
        return {d3_hs, d3_vs, d3_vid, d3_ls, d3_fs, d3_x, d3_y, d3_fc};
    endfunction

    task automatic sb_check();
        out_t e;
        if (q0.size() == 0 || q3.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = q0.pop_front();
            chk("d0_out", 64'(d0_out()), 64'(e));
            e.fc = {6'b000000, e.fc[1:0]};
            chk("d2_out", 64'(d2_out()), 64'(e));
            e = q3.pop_front();
            chk("d3_out", 64'(d3_out()), 64'(e));
        end
        if (cyc >= 1 && cyc <= 14 && !d0_hs) hs_low++;
        if (cyc >= 1 && cyc <= 112 && !d0_vs) vs_low++;
        if (d0_fs) fs_cnt++;
    endtask

    // One clock: model consumes en at the edge, expectations go to the scoreboards
    task automatic step();
        out_t e;
        @(posedge clk);
        e = model_dec(mh, mv, en, mfc);
        if (!en) begin
            mh = 0;
            mv = 0;
        end else if (mh == 13) begin
            mh = 0;
            if (mv == 7) begin
                mv = 0;
                mfc++;
            end else begin
                mv++;
            end
        end else begin
            mh++;
        end
        q0.push_back(e);
        q3.push_back(e);
        cyc++;
        #1;
        sb_check();
    endtask

    task automatic chk_rst(input string name);
        chk({name, "_d0"}, 64'(d0_out()), 64'(RST));
        chk({name, "_d2"}, 64'(d2_out()), 64'(RST));
        chk({name, "_d3"}, 64'(d3_out()), 64'(RST));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk_rst("async_clr");
        mh = 0;
        mv = 0;
        mfc = 0;
        q0.delete();
        q3.delete();
        repeat (3) q3.push_back(RST);
        @(posedge clk);
        #1;
        chk_rst("rst_hold");
        rst_n = 1'b1;
        cyc = 0;
        fs_cnt = 0;
    endtask

    initial begin
        tbl[0] = '{cyc: 1,  hs: 1'b1, vid: 1'b1, ls: 1'b1, fs: 1'b1, x: 0,  y: 0};
        tbl[1] = '{cyc: 8,  hs: 1'b1, vid: 1'b1, ls: 1'b0, fs: 1'b0, x: 7,  y: 0};
        tbl[2] = '{cyc: 9,  hs: 1'b1, vid: 1'b0, ls: 1'b0, fs: 1'b0, x: 8,  y: 0};
        tbl[3] = '{cyc: 11, hs: 1'b0, vid: 1'b0, ls: 1'b0, fs: 1'b0, x: 10, y: 0};
        tbl[4] = '{cyc: 13, hs: 1'b0, vid: 1'b0, ls: 1'b0, fs: 1'b0, x: 12, y: 0};
        tbl[5] = '{cyc: 14, hs: 1'b1, vid: 1'b0, ls: 1'b0, fs: 1'b0, x: 13, y: 0};
        tbl[6] = '{cyc: 15, hs: 1'b1, vid: 1'b1, ls: 1'b1, fs: 1'b0, x: 0,  y: 1};

        #2;
        en = 1'b1;
        apply_reset();

        for (int i = 0; i < 7; i++) begin
            while (cyc < tbl[i].cyc) step();
            chk("tbl_x",   64'(d0_x),   64'(tbl[i].x));
            chk("tbl_y",   64'(d0_y),   64'(tbl[i].y));
            chk("tbl_hs",  64'(d0_hs),  64'(tbl[i].hs));
            chk("tbl_vid", 64'(d0_vid), 64'(tbl[i].vid));
            chk("tbl_ls",  64'(d0_ls),  64'(tbl[i].ls));
            chk("tbl_fs",  64'(d0_fs),  64'(tbl[i].fs));
        end

        // Five full frames: wrap of the 2-bit frame counter
        while (cyc < 561) step();
        chk("hs_width",    64'(hs_low), 64'd3);
        chk("vs_width",    64'(vs_low), 64'd28);
        chk("fs_count",    64'(fs_cnt), 64'd6);
        chk("f5_fs",       64'(d0_fs),  64'd1);
        chk("f5_fc8",      64'(d0_fc),  64'd5);
        chk("f5_fc2",      64'(d2_fc),  64'd1);

        // Pause at (5,2) for four cycles, then restart at the origin
        for (int k = 0; k < 200 && !(mh == 5 && mv == 2); k++) step();
        chk("pause_pos", 64'(mh * 100 + mv), 64'd502);
        en = 1'b0;
        step();
        chk("pause_vid", 64'(d0_vid), 64'd0);
        chk("pause_x",   64'(d0_x),   64'd0);
        chk("pause_hs",  64'(d0_hs),  64'd1);
        chk("pause_fc",  64'(d0_fc),  64'd5);
        repeat (3) step();
        en = 1'b1;
        step();
        chk("restart_fs", 64'(d0_fs), 64'd1);
        chk("restart_xy", 64'({d0_x, d0_y}), 64'd0);
        chk("restart_fc", 64'(d0_fc), 64'd5);
        chk("restart_fc2", 64'(d2_fc), 64'd1);

        // Mid-frame reset with the delayed instance watched closely
        repeat (30) step();
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("dly_fs", 64'(d3_fs), (k == 4) ? 64'd1 : 64'd0);
        end
        chk("dly_xy",  64'({d3_x, d3_y}), 64'd0);
        chk("dly_vid", 64'(d3_vid), 64'd1);
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
